// File: rtl/npc_ctrl_pkg.sv
// npc_ctrl_pkg: shared encodings for the NPC core control sequencer.
//   state_e      - 3-bit sequencer state (RESET=0 .. HALT=7)
//   PC_SEL_*     - next-PC source select
//   CAUSE_*      - mcause codes written on a trap
//   dec_flags_t  - decoder flags held from DECODE through WB
package npc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6,
    ST_HALT   = 3'd7
  } state_e;

  localparam logic [1:0] PC_SEL_NPC   = 2'd0;
  localparam logic [1:0] PC_SEL_MTVEC = 2'd1;
  localparam logic [1:0] PC_SEL_MEPC  = 2'd2;

  localparam logic [3:0] CAUSE_IFETCH_FAULT = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL      = 4'd2;
  localparam logic [3:0] CAUSE_LOAD_FAULT   = 4'd5;
  localparam logic [3:0] CAUSE_STORE_FAULT  = 4'd7;
  localparam logic [3:0] CAUSE_ECALL_M      = 4'd11;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic is_csr;
    logic mret;
  } dec_flags_t;

endpackage

// File: rtl/core_ctrl_fsm_if.sv
// core_ctrl_fsm_if: IFU / LSU request handshakes of the control sequencer.
//   ifu_req / ifu_rvalid  - fetch request, held until the fetch completes
//   inst_latch            - IR capture pulse in the fetch-complete cycle
//   lsu_req / lsu_we      - memory request (we: 1 store, 0 load)
//   lsu_rvalid            - memory completion
// master: the sequencer; slave: the IFU/LSU side.
interface core_ctrl_fsm_if;
  logic ifu_req;
  logic ifu_rvalid;
  logic inst_latch;
  logic lsu_req;
  logic lsu_we;
  logic lsu_rvalid;

  modport master (output ifu_req, inst_latch, lsu_req, lsu_we,
                  input  ifu_rvalid, lsu_rvalid);
  modport slave  (input  ifu_req, inst_latch, lsu_req, lsu_we,
                  output ifu_rvalid, lsu_rvalid);
endinterface

// File: rtl/core_ctrl_fsm_bus_wait_timer.sv
// bus_wait_timer: counts cycles a bus request waits for its response.
//   clk, rst_n  - clock, async active-low reset
//   i_clear     - hold the count at zero (request not outstanding)
//   i_tick      - one waiting cycle without a response
//   o_expired   - count has reached TIMEOUT_CYCLES-1
module bus_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] r_cnt;

  assign o_expired = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Count stops at the limit; the owner leaves the wait state that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_cnt <= '0;
    else if (i_clear)               r_cnt <= '0;
    else if (i_tick && !o_expired)  r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm: multi-cycle control sequencer for the NPC core.
// FETCH -> DECODE -> EXEC -> [MEM] -> WB, with TRAP (ecall / illegal /
// bus timeout) and a sticky HALT on ebreak.
//   clk, rst_n          - clock, async active-low reset
//   bus (master)        - IFU/LSU handshakes, see core_ctrl_fsm_if
//   dec_*               - decoder flags, sampled in DECODE
//   rf_we, csr_we       - register-file / CSR write strobes (WB)
//   pc_we, pc_sel       - PC update strobe and source
//   trap_we, trap_cause - mepc/mcause write strobe and cause
//   halt                - sticky halt after ebreak
//   instret             - retired-instruction counter (wraps)
//   state_o             - current state for trace
// Optional: define NPC_BUS_TIMEOUT_EN to trap fetch/load/store requests
// that wait TIMEOUT_CYCLES without a response.
module core_ctrl_fsm
  import npc_ctrl_pkg::*;
#(
  parameter int unsigned INSTRET_W      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  core_ctrl_fsm_if.master      bus,
  input  logic                 dec_mem_read,
  input  logic                 dec_mem_write,
  input  logic                 dec_reg_write,
  input  logic                 dec_is_csr,
  input  logic                 dec_ecall,
  input  logic                 dec_ebreak,
  input  logic                 dec_mret,
  input  logic                 dec_illegal,
  output logic                 rf_we,
  output logic                 csr_we,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic                 trap_we,
  output logic [3:0]           trap_cause,
  output logic                 halt,
  output logic [INSTRET_W-1:0] instret,
  output logic [2:0]           state_o
);

  state_e               r_state, w_next;
  dec_flags_t           r_flags;
  logic [3:0]           r_cause;
  logic [INSTRET_W-1:0] r_instret;
  logic                 w_timeout;
  logic                 w_ifu_req, w_inst_latch, w_lsu_req, w_lsu_we;

`ifdef NPC_BUS_TIMEOUT_EN
  logic w_waiting, w_rvalid, w_expired;
  assign w_waiting = (r_state == ST_FETCH) || (r_state == ST_MEM);
  assign w_rvalid  = (r_state == ST_FETCH) ? bus.ifu_rvalid : bus.lsu_rvalid;

  // Cleared in every non-waiting state, so it starts at zero on entry.
  bus_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (!w_waiting),
    .i_tick    (w_waiting && !w_rvalid),
    .o_expired (w_expired)
  );
  // A response in the expiry cycle wins over the timeout.
  assign w_timeout = w_waiting && !w_rvalid && w_expired;
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RESET;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RESET:  w_next = ST_FETCH;
      ST_FETCH:  if (bus.ifu_rvalid)  w_next = ST_DECODE;
                 else if (w_timeout)  w_next = ST_TRAP;
      ST_DECODE: if (dec_illegal)     w_next = ST_TRAP;
                 else if (dec_ebreak) w_next = ST_HALT;
                 else if (dec_ecall)  w_next = ST_TRAP;
                 else                 w_next = ST_EXEC;
      ST_EXEC:   w_next = (r_flags.mem_read || r_flags.mem_write) ? ST_MEM : ST_WB;
      ST_MEM:    if (bus.lsu_rvalid)  w_next = ST_WB;
                 else if (w_timeout)  w_next = ST_TRAP;
      ST_WB,
      ST_TRAP:   w_next = ST_FETCH;
      ST_HALT:   w_next = ST_HALT;
      default:   w_next = ST_RESET;
    endcase
  end

  // Flags, trap cause and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags   <= '0;
      r_cause   <= '0;
      r_instret <= '0;
    end else begin
      if (r_state == ST_DECODE) begin
        r_flags <= '{mem_read:  dec_mem_read,  mem_write: dec_mem_write,
                     reg_write: dec_reg_write, is_csr:    dec_is_csr,
                     mret:      dec_mret};
        r_cause <= dec_illegal ? CAUSE_ILLEGAL : CAUSE_ECALL_M;
      end
      if (w_timeout) begin
        if (r_state == ST_FETCH)    r_cause <= CAUSE_IFETCH_FAULT;
        else if (r_flags.mem_write) r_cause <= CAUSE_STORE_FAULT;
        else                        r_cause <= CAUSE_LOAD_FAULT;
      end
      if (r_state == ST_WB) r_instret <= r_instret + 1'b1;
    end
  end

  // Output decode
  always_comb begin
    w_ifu_req    = 1'b0;
    w_inst_latch = 1'b0;
    w_lsu_req    = 1'b0;
    w_lsu_we     = 1'b0;
    rf_we        = 1'b0;
    csr_we       = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_SEL_NPC;
    trap_we      = 1'b0;
    trap_cause   = 4'd0;
    halt         = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_ifu_req    = 1'b1;
        w_inst_latch = bus.ifu_rvalid;
      end
      ST_MEM: begin
        w_lsu_req = 1'b1;
        w_lsu_we  = r_flags.mem_write;
      end
      ST_WB: begin
        rf_we  = r_flags.reg_write;
        csr_we = r_flags.is_csr;
        pc_we  = 1'b1;
        pc_sel = r_flags.mret ? PC_SEL_MEPC : PC_SEL_NPC;
      end
      ST_TRAP: begin
        trap_we    = 1'b1;
        pc_we      = 1'b1;
        pc_sel     = PC_SEL_MTVEC;
        trap_cause = r_cause;
      end
      ST_HALT: halt = 1'b1;
      default: ;
    endcase
  end

  assign bus.ifu_req    = w_ifu_req;
  assign bus.inst_latch = w_inst_latch;
  assign bus.lsu_req    = w_lsu_req;
  assign bus.lsu_we     = w_lsu_we;
  assign instret        = r_instret;
  assign state_o        = r_state;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// tb_core_ctrl_fsm: scoreboard bench for core_ctrl_fsm. Expected per-cycle
// outputs are queued alongside the inputs for that cycle, then each task
// replays the inputs and compares. Build with NPC_BUS_TIMEOUT_EN to
// exercise the bus timeout (TIMEOUT_CYCLES=4).
module tb_core_ctrl_fsm;

  localparam int TO = 4;

  typedef struct packed {
    logic mr, mw, rw, csr, ecall, ebreak, mret, illegal;
  } dec_t;

  typedef struct packed {
    logic ifu_rv, lsu_rv;
    dec_t f;
  } in_t;

  typedef struct packed {
    logic [2:0] st;
    logic       ifu_req, inst_latch, lsu_req, lsu_we, rf_we, csr_we, pc_we;
    logic [1:0] pc_sel;
    logic       trap_we;
    logic [3:0] cause;
    logic       halt;
    logic [3:0] instret;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dec_mem_read, dec_mem_write, dec_reg_write, dec_is_csr;
  logic       dec_ecall, dec_ebreak, dec_mret, dec_illegal;
  logic       rf_we, csr_we, pc_we, trap_we, halt;
  logic [1:0] pc_sel;
  logic [3:0] trap_cause;
  logic [3:0] instret;
  logic [2:0] state_o;

  core_ctrl_fsm_if bus();

  core_ctrl_fsm #(.INSTRET_W(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
    .dec_reg_write(dec_reg_write), .dec_is_csr(dec_is_csr),
    .dec_ecall(dec_ecall), .dec_ebreak(dec_ebreak),
    .dec_mret(dec_mret), .dec_illegal(dec_illegal),
    .rf_we(rf_we), .csr_we(csr_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .trap_we(trap_we), .trap_cause(trap_cause), .halt(halt),
    .instret(instret), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] m_instret = 4'd0;
  obs_t       exp_q[$];
  in_t        in_q[$];
  obs_t       got, want;

  // ---------------- helpers (stimulus / model only) ----------------
  function automatic obs_t sample();
    obs_t o;
    o.st = state_o;         o.ifu_req = bus.ifu_req; o.inst_latch = bus.inst_latch;
    o.lsu_req = bus.lsu_req; o.lsu_we = bus.lsu_we;  o.rf_we = rf_we;
    o.csr_we = csr_we;      o.pc_we = pc_we;         o.pc_sel = pc_sel;
    o.trap_we = trap_we;    o.cause = trap_cause;    o.halt = halt;
    o.instret = instret;
    return o;
  endfunction

  function automatic obs_t base(input logic [2:0] st);
    obs_t e = '0;
    e.st = st;
    e.instret = m_instret;
    return e;
  endfunction

  // Random inputs: anything the FSM is supposed to ignore in this cycle.
  function automatic in_t rnd();
    logic [31:0] v = $urandom;
    return in_t'(v[9:0]);
  endfunction

  task automatic apply(input in_t i);
    bus.ifu_rvalid = i.ifu_rv;   bus.lsu_rvalid = i.lsu_rv;
    dec_mem_read = i.f.mr;       dec_mem_write = i.f.mw;
    dec_reg_write = i.f.rw;      dec_is_csr = i.f.csr;
    dec_ecall = i.f.ecall;       dec_ebreak = i.f.ebreak;
    dec_mret = i.f.mret;         dec_illegal = i.f.illegal;
  endtask

  task automatic push(input obs_t e, input in_t i);
    exp_q.push_back(e);
    in_q.push_back(i);
  endtask

  task automatic push_fetch(input int fw);
    obs_t e; in_t i;
    for (int k = 0; k <= fw; k++) begin
      e = base(3'd1); e.ifu_req = 1'b1; e.inst_latch = (k == fw);
      i = rnd(); i.ifu_rv = (k == fw);
      push(e, i);
    end
  endtask

  // Reference sequence for one instruction; fw/mw = bus wait cycles.
  task automatic gen_instr(input dec_t f, input int fw, input int mw);
    obs_t e; in_t i;
    push_fetch(fw);
    i = rnd(); i.f = f;
    push(base(3'd2), i);
    if (f.illegal || (!f.ebreak && f.ecall)) begin
      e = base(3'd6); e.trap_we = 1'b1; e.pc_we = 1'b1; e.pc_sel = 2'd1;
      e.cause = f.illegal ? 4'd2 : 4'd11;
      push(e, rnd());
      return;
    end
    if (f.ebreak) return;
    push(base(3'd3), rnd());
    if (f.mr || f.mw) begin
      for (int k = 0; k <= mw; k++) begin
        e = base(3'd4); e.lsu_req = 1'b1; e.lsu_we = f.mw;
        i = rnd(); i.lsu_rv = (k == mw);
        push(e, i);
      end
    end
    e = base(3'd5); e.rf_we = f.rw; e.csr_we = f.csr; e.pc_we = 1'b1;
    e.pc_sel = f.mret ? 2'd2 : 2'd0;
    push(e, rnd());
    m_instret = m_instret + 4'd1;
  endtask

  function automatic dec_t mk(input logic mr, mw, rw, csr, ecall, ebreak, mret, illegal);
    dec_t d;
    d.mr = mr; d.mw = mw; d.rw = rw; d.csr = csr;
    d.ecall = ecall; d.ebreak = ebreak; d.mret = mret; d.illegal = illegal;
    return d;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk); apply(rnd()); #2 rst_n = 1'b0; m_instret = 4'd0;
    #1 got = sample(); want = base(3'd0); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL reset_low got=%h want=%h", got, want); end
    @(negedge clk); apply(rnd()); rst_n = 1'b1;
    #1 got = sample(); want = base(3'd0); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL reset_release got=%h want=%h", got, want); end
  endtask

  task automatic test_alu();
    gen_instr(mk(0,0,1,0,0,0,0,0), 0, 0);   // addi, zero-wait
    gen_instr(mk(0,0,1,1,0,0,0,0), 1, 0);   // csrrw, one fetch wait
    while (exp_q.size() > 0) begin
      @(negedge clk); apply(in_q.pop_front());
      #1 got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL alu got=%h want=%h", got, want); end
    end
  endtask

  task automatic test_load();
    gen_instr(mk(1,0,1,0,0,0,0,0), 0, 3);   // lw, rvalid 3 cycles late
    while (exp_q.size() > 0) begin
      @(negedge clk); apply(in_q.pop_front());
      #1 got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL load got=%h want=%h", got, want); end
    end
  endtask

  task automatic test_store_mret();
    gen_instr(mk(0,1,0,0,0,0,0,0), 0, 1);   // sw
    gen_instr(mk(1,1,1,0,0,0,0,0), 0, 0);   // read+write: behaves as store
    gen_instr(mk(0,0,0,0,0,0,1,0), 0, 0);   // mret
    while (exp_q.size() > 0) begin
      @(negedge clk); apply(in_q.pop_front());
      #1 got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL store_mret got=%h want=%h", got, want); end
    end
  endtask

  task automatic test_traps();
    gen_instr(mk(0,0,1,0,1,0,0,0), 0, 0);   // ecall
    gen_instr(mk(0,0,1,0,1,1,0,1), 0, 0);   // illegal beats ebreak and ecall
    gen_instr(mk(1,1,1,1,1,0,1,0), 0, 0);   // ecall with other flags set
    while (exp_q.size() > 0) begin
      @(negedge clk); apply(in_q.pop_front());
      #1 got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL traps got=%h want=%h", got, want); end
    end
  endtask

  // Enough retires to wrap the 4-bit instret counter.
  task automatic test_back_to_back();
    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 5))
        0: gen_instr(mk(0,0,1,0,0,0,0,0), $urandom_range(0,2), 0);
        1: gen_instr(mk(0,0,1,1,0,0,0,0), $urandom_range(0,2), 0);
        2: gen_instr(mk(1,0,1,0,0,0,0,0), $urandom_range(0,2), $urandom_range(0,2));
        3: gen_instr(mk(0,1,0,0,0,0,0,0), $urandom_range(0,2), $urandom_range(0,2));
        4: gen_instr(mk(0,0,0,0,0,0,1,0), $urandom_range(0,2), 0);
        default: gen_instr(mk(0,0,0,0,1,0,0,0), 0, 0);
      endcase
    end
    while (exp_q.size() > 0) begin
      @(negedge clk); apply(in_q.pop_front());
      #1 got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL back_to_back got=%h want=%h", got, want); end
    end
  endtask

  task automatic test_bus_wait();
    obs_t e; in_t i;
`ifdef NPC_BUS_TIMEOUT_EN
    // Fetch: no response for TO cycles -> TRAP cause 1.
    for (int k = 0; k < TO; k++) begin
      e = base(3'd1); e.ifu_req = 1'b1; i = rnd(); i.ifu_rv = 1'b0; push(e, i);
    end
    e = base(3'd6); e.trap_we = 1'b1; e.pc_we = 1'b1; e.pc_sel = 2'd1; e.cause = 4'd1;
    push(e, rnd());
    // Load (cause 5) and store (cause 7) that never complete.
    for (int s = 0; s < 2; s++) begin
      push_fetch(0);
      i = rnd(); i.f = (s == 0) ? mk(1,0,1,0,0,0,0,0) : mk(0,1,0,0,0,0,0,0);
      push(base(3'd2), i);
      push(base(3'd3), rnd());
      for (int k = 0; k < TO; k++) begin
        e = base(3'd4); e.lsu_req = 1'b1; e.lsu_we = (s == 1);
        i = rnd(); i.lsu_rv = 1'b0; push(e, i);
      end
      e = base(3'd6); e.trap_we = 1'b1; e.pc_we = 1'b1; e.pc_sel = 2'd1;
      e.cause = (s == 0) ? 4'd5 : 4'd7;
      push(e, rnd());
    end
    // Response in the expiry cycle wins.
    gen_instr(mk(0,0,1,0,0,0,0,0), TO - 1, 0);
    gen_instr(mk(1,0,1,0,0,0,0,0), 0, TO - 1);
`else
    // Without the timeout the FSM waits as long as it takes.
    gen_instr(mk(0,0,1,0,0,0,0,0), 20, 0);
    gen_instr(mk(0,1,0,0,0,0,0,0), 0, 20);
    e = base(3'd0); i = rnd(); // keeps e/i used in this build
    if (e.st !== 3'd0 || i === 10'bx) ;
`endif
    while (exp_q.size() > 0) begin
      @(negedge clk); apply(in_q.pop_front());
      #1 got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL bus_wait got=%h want=%h", got, want); end
    end
  endtask

  task automatic test_halt();
    obs_t e;
    gen_instr(mk(0,0,1,0,0,1,0,0), 0, 0);   // ebreak
    for (int k = 0; k < 100; k++) begin
      e = base(3'd7); e.halt = 1'b1; push(e, rnd());
    end
    while (exp_q.size() > 0) begin
      @(negedge clk); apply(in_q.pop_front());
      #1 got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL halt got=%h want=%h", got, want); end
    end
  endtask

  task automatic test_reset_mid_mem();
    gen_instr(mk(1,0,1,0,0,0,0,0), 0, 8);
    repeat (5) begin   // FETCH, DECODE, EXEC, MEM, MEM
      @(negedge clk); apply(in_q.pop_front());
      #1 got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL mid_mem_pre got=%h want=%h", got, want); end
    end
    exp_q.delete(); in_q.delete();
    // Mid-cycle, away from any clock edge.
    #1 rst_n = 1'b0; m_instret = 4'd0;
    #1 got = sample(); want = base(3'd0); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL mid_mem_async got=%h want=%h", got, want); end
    @(negedge clk); apply(rnd()); rst_n = 1'b1;
    #1 got = sample(); want = base(3'd0); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL mid_mem_release got=%h want=%h", got, want); end
  endtask

  initial begin
    apply('0);
    test_reset();
    test_alu();
    test_load();
    test_store_mret();
    test_traps();
    test_back_to_back();
    test_bus_wait();
    test_halt();
    test_reset();
    test_alu();
    test_reset_mid_mem();
    test_alu();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, compared=%0d", n_cmp);
    $fatal(1);
  end

endmodule
